// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan-chain test sequencer.
package scan_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } scan_state_e;

    localparam int DEFAULT_CHAIN_LEN      = 8;
    localparam int DEFAULT_CAPTURE_CYCLES = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_seq_ctrl_if.sv
// Host-side and chain-side pins of the scan sequencer, bundled with modports.
interface scan_seq_ctrl_if
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pattern;
    logic [CHAIN_LEN-1:0] expect_vec;
    logic [CHAIN_LEN-1:0] mask;
    logic                 scan_out0;
    logic                 scan_in0;
    logic                 scan_en;
    logic                 test_mode;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CHAIN_LEN-1:0] captured;

    modport master (
        output start, pattern, expect_vec, mask, scan_out0,
        input  scan_in0, scan_en, test_mode, busy, done, pass, captured
    );

    modport slave (
        input  start, pattern, expect_vec, mask, scan_out0,
        output scan_in0, scan_en, test_mode, busy, done, pass, captured
    );
endinterface

// File: rtl/scan_shift_cnt.sv
// Loadable down-counter with zero flag; times the load, capture and unload phases.
module scan_shift_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_r;

    // Load wins over decrement; the count parks at zero until reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (srst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});
endmodule

// File: rtl/scan_seq_ctrl.sv
// Sequences one scan test: shift-in, functional capture, shift-out, masked compare.
module scan_seq_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN      = DEFAULT_CHAIN_LEN,
    parameter int CAPTURE_CYCLES = DEFAULT_CAPTURE_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          srst,
    scan_seq_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(max_int(CHAIN_LEN, CAPTURE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);

    scan_state_e          state_r, state_next_s;
    logic                 cnt_load_s, cnt_en_s, cnt_zero_s;
    logic [CNT_W-1:0]     cnt_val_s;
    logic                 start_acc_s, pass_cmp_s;
    logic [CHAIN_LEN-1:0] pat_r, exp_r, mask_r, captured_r, captured_next_s;
    logic                 scan_in0_r, scan_en_r, test_mode_r, busy_r, done_r, pass_r;

    assign start_acc_s = (state_r == IDLE) && bus.start;
    assign cnt_en_s    = (state_r == LOAD) || (state_r == CAPTURE) || (state_r == UNLOAD);
    assign pass_cmp_s  = (((captured_next_s ^ exp_r) & mask_r) == {CHAIN_LEN{1'b0}});

    scan_shift_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .srst     (srst),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .en       (cnt_en_s),
        .zero     (cnt_zero_s)
    );

    // Next-state logic; each phase reloads the counter with its last-cycle index.
    always_comb begin
        state_next_s = state_r;
        cnt_load_s   = 1'b0;
        cnt_val_s    = {CNT_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s = LOAD;
                    cnt_load_s   = 1'b1;
                    cnt_val_s    = SHIFT_LAST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (cnt_zero_s) begin
                    state_next_s = CAPTURE;
                    cnt_load_s   = 1'b1;
                    cnt_val_s    = CAP_LAST;
                end else begin
                    state_next_s = LOAD;
                end
            end
            CAPTURE: begin
                if (cnt_zero_s) begin
                    state_next_s = UNLOAD;
                    cnt_load_s   = 1'b1;
                    cnt_val_s    = SHIFT_LAST;
                end else begin
                    state_next_s = CAPTURE;
                end
            end
            UNLOAD: begin
                if (cnt_zero_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = UNLOAD;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Unload fills from the top so the first bit out lands in captured[0].
    always_comb begin
        captured_next_s = captured_r;
        if (state_r == UNLOAD) begin
            captured_next_s = {bus.scan_out0, captured_r[CHAIN_LEN-1:1]};
        end else begin
            captured_next_s = captured_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else if (srst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shadow operands; the pattern shadow drains LSB-first while loading.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_r  <= {CHAIN_LEN{1'b0}};
            exp_r  <= {CHAIN_LEN{1'b0}};
            mask_r <= {CHAIN_LEN{1'b0}};
        end else if (srst) begin
            pat_r  <= {CHAIN_LEN{1'b0}};
            exp_r  <= {CHAIN_LEN{1'b0}};
            mask_r <= {CHAIN_LEN{1'b0}};
        end else if (start_acc_s) begin
            pat_r  <= {1'b0, bus.pattern[CHAIN_LEN-1:1]};
            exp_r  <= bus.expect_vec;
            mask_r <= bus.mask;
        end else if (state_r == LOAD) begin
            pat_r  <= {1'b0, pat_r[CHAIN_LEN-1:1]};
        end else begin
            pat_r  <= pat_r;
        end
    end

    // Chain pins are registered from the next state so they change only on phase edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_in0_r  <= 1'b0;
            scan_en_r   <= 1'b0;
            test_mode_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else if (srst) begin
            scan_in0_r  <= 1'b0;
            scan_en_r   <= 1'b0;
            test_mode_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            scan_en_r   <= (state_next_s == LOAD) || (state_next_s == UNLOAD);
            test_mode_r <= (state_next_s == LOAD) || (state_next_s == CAPTURE) ||
                           (state_next_s == UNLOAD);
            busy_r      <= (state_next_s == LOAD) || (state_next_s == CAPTURE) ||
                           (state_next_s == UNLOAD);
            done_r      <= (state_next_s == DONE);
            if (start_acc_s) begin
                scan_in0_r <= bus.pattern[0];
            end else if ((state_r == LOAD) && (state_next_s == LOAD)) begin
                scan_in0_r <= pat_r[0];
            end else begin
                scan_in0_r <= 1'b0;
            end
        end
    end

    // Results are cleared on an accepted start and held after the compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            captured_r <= {CHAIN_LEN{1'b0}};
            pass_r     <= 1'b0;
        end else if (srst) begin
            captured_r <= {CHAIN_LEN{1'b0}};
            pass_r     <= 1'b0;
        end else if (start_acc_s) begin
            captured_r <= {CHAIN_LEN{1'b0}};
            pass_r     <= 1'b0;
        end else begin
            captured_r <= captured_next_s;
            if ((state_r == UNLOAD) && (state_next_s == DONE)) begin
                pass_r <= pass_cmp_s;
            end else begin
                pass_r <= pass_r;
            end
        end
    end

    assign bus.scan_in0  = scan_in0_r;
    assign bus.scan_en   = scan_en_r;
    assign bus.test_mode = test_mode_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.captured  = captured_r;
endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Bench for scan_seq_ctrl: an 8-bit/1-capture and a 4-bit/3-capture instance against chain models.
module tb_scan_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic srst;
    always #5 clk = ~clk;

    scan_seq_ctrl_if #(.CHAIN_LEN(8)) if8();
    scan_seq_ctrl_if #(.CHAIN_LEN(4)) if4();

    scan_seq_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYCLES(1)) u_dut8 (
        .clk(clk), .reset(reset), .srst(srst), .bus(if8));
    scan_seq_ctrl #(.CHAIN_LEN(4), .CAPTURE_CYCLES(3)) u_dut4 (
        .clk(clk), .reset(reset), .srst(srst), .bus(if4));

    // Chain models: head at bit 0, tail at top bit; capture optionally inverts.
    logic [7:0] chain8 = 8'h00;
    logic [3:0] chain4 = 4'h0;
    bit         inv8   = 1'b0;
    assign if8.scan_out0 = chain8[7];
    assign if4.scan_out0 = chain4[3];

    always @(posedge clk) begin
        if (if8.scan_en) chain8 <= {chain8[6:0], if8.scan_in0};
        else if (if8.test_mode && inv8) chain8 <= ~chain8;
    end
    always @(posedge clk) begin
        if (if4.scan_en) chain4 <= {chain4[2:0], if4.scan_in0};
    end

    int checks = 0;
    int failures = 0;

    // Reference model: which test is running and when it was accepted.
    int         edge_n = 0;
    bit         has8 = 1'b0, has4 = 1'b0, mi8 = 1'b0;
    int         st8 = 0, st4 = 0;
    logic [7:0] p8 = 8'h00, e8 = 8'h00, m8 = 8'h00;
    logic [3:0] p4 = 4'h0, e4 = 4'h0, m4 = 4'h0;
    int         done_cnt8 = 0, done_t8 = -1, done_cnt4 = 0, done_t4 = -1;
    logic [17:0] en_hist8 = 18'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            has8 = 1'b0;
            has4 = 1'b0;
        end else begin
            edge_n++;
            if (if8.start && (!has8 || (edge_n - st8) >= 2*8 + 1 + 2)) begin
                has8 = 1'b1; st8 = edge_n; mi8 = inv8;
                p8 = if8.pattern; e8 = if8.expect_vec; m8 = if8.mask;
            end
            if (if4.start && (!has4 || (edge_n - st4) >= 2*4 + 3 + 2)) begin
                has4 = 1'b1; st4 = edge_n;
                p4 = if4.pattern; e4 = if4.expect_vec; m4 = if4.mask;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check(input string tag, input int n, input int c, input bit has,
                               input int t, input logic [7:0] p, input logic [7:0] cap_exp,
                               input bit pass_exp, input logic si, input logic se,
                               input logic tm, input logic bz, input logic dn,
                               input logic ps, input logic [7:0] cap);
        int l;
        l = 2*n + c;
        if (!has) begin
            chk({tag, "_idle_scan_in0"}, si, 0);
            chk({tag, "_idle_scan_en"}, se, 0);
            chk({tag, "_idle_test_mode"}, tm, 0);
            chk({tag, "_idle_busy"}, bz, 0);
            chk({tag, "_idle_done"}, dn, 0);
            chk({tag, "_idle_pass"}, ps, 0);
            chk({tag, "_idle_captured"}, cap, 0);
        end else begin
            chk({tag, "_scan_in0"}, si, (t < n) ? p[t] : 1'b0);
            chk({tag, "_scan_en"}, se, (t < n) || (t >= n + c && t < l));
            chk({tag, "_test_mode"}, tm, t < l);
            chk({tag, "_busy"}, bz, t < l);
            chk({tag, "_done"}, dn, t == l);
            if (t >= l) begin
                chk({tag, "_captured"}, cap, cap_exp);
                chk({tag, "_pass"}, ps, pass_exp);
            end else begin
                chk({tag, "_pass_cleared"}, ps, 0);
            end
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [7:0] c8, c4;
        int t8, t4;
        t8 = edge_n - st8;
        t4 = edge_n - st4;
        c8 = mi8 ? ~p8 : p8;
        c4 = {4'h0, p4};
        model_check("dut8", 8, 1, has8, t8, p8, c8, ((c8 ^ e8) & m8) == 8'h00,
                    if8.scan_in0, if8.scan_en, if8.test_mode, if8.busy, if8.done,
                    if8.pass, if8.captured);
        model_check("dut4", 4, 3, has4, t4, {4'h0, p4}, c4,
                    ((c4[3:0] ^ e4) & m4) == 4'h0,
                    if4.scan_in0, if4.scan_en, if4.test_mode, if4.busy, if4.done,
                    if4.pass, {4'h0, if4.captured});
        if (has8 && t8 == 0) en_hist8 = 18'h0;
        if (has8 && t8 >= 0 && t8 < 18) en_hist8[t8] = if8.scan_en;
        if (if8.done) begin done_cnt8++; done_t8 = t8; end
        if (if4.done) begin done_cnt4++; done_t4 = t4; end
    end

    task automatic start8(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m);
        if8.pattern = p; if8.expect_vec = e; if8.mask = m; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0; if8.pattern = ~p;
    endtask

    task automatic start4(input logic [3:0] p, input logic [3:0] e, input logic [3:0] m);
        if4.pattern = p; if4.expect_vec = e; if4.mask = m; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0; if4.pattern = ~p;
    endtask

    initial begin
        int d0;
        reset = 1'b0; srst = 1'b0;
        if8.start = 1'b0; if8.pattern = 8'h00; if8.expect_vec = 8'h00; if8.mask = 8'h00;
        if4.start = 1'b0; if4.pattern = 4'h0; if4.expect_vec = 4'h0; if4.mask = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy8", if8.busy, 0);
        chk("rst_captured8", if8.captured, 0);
        reset = 1'b1;
        @(negedge clk);

        // Pure shift, A5
        d0 = done_cnt8;
        start8(8'hA5, 8'hA5, 8'hFF);
        repeat (19) @(negedge clk);
        chk("t1_captured", if8.captured, 8'hA5);
        chk("t1_pass", if8.pass, 1);
        chk("t1_latency", done_t8, 17);
        chk("t1_done_pulses", done_cnt8 - d0, 1);
        chk("t1_scan_en_window", en_hist8, 18'h1FEFF);

        // Inverting capture
        inv8 = 1'b1;
        start8(8'h3C, 8'hC3, 8'hFF);
        repeat (19) @(negedge clk);
        chk("t2_captured", if8.captured, 8'hC3);
        chk("t2_pass", if8.pass, 1);
        start8(8'h3C, 8'h3C, 8'hFF);
        repeat (19) @(negedge clk);
        chk("t2b_captured", if8.captured, 8'hC3);
        chk("t2b_pass", if8.pass, 0);
        start8(8'h3C, 8'h00, 8'h00);
        repeat (19) @(negedge clk);
        chk("t3_mask0_pass", if8.pass, 1);
        start8(8'h3C, 8'hC2, 8'h01);
        repeat (19) @(negedge clk);
        chk("t3_mask1_pass", if8.pass, 0);

        // start during LOAD and during DONE is ignored
        inv8 = 1'b0;
        d0 = done_cnt8;
        start8(8'h5A, 8'h5A, 8'hFF);
        repeat (2) @(negedge clk);
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (14) @(negedge clk);
        chk("t4_done_cycle", if8.done, 1);
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        chk("t4_idle_after_done", if8.busy, 0);
        repeat (2) @(negedge clk);
        chk("t4_done_pulses", done_cnt8 - d0, 1);
        chk("t4_captured", if8.captured, 8'h5A);

        // Reset mid-unload
        d0 = done_cnt8;
        start8(8'h96, 8'h96, 8'hFF);
        repeat (12) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_scan_en", if8.scan_en, 0);
        chk("t5_async_busy", if8.busy, 0);
        chk("t5_async_test_mode", if8.test_mode, 0);
        chk("t5_async_captured", if8.captured, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_no_done", done_cnt8 - d0, 0);
        start8(8'hFF, 8'hFF, 8'hFF);
        repeat (19) @(negedge clk);
        chk("t5_captured", if8.captured, 8'hFF);
        chk("t5_pass", if8.pass, 1);
        chk("t5_done_pulses", done_cnt8 - d0, 1);

        // 4-bit chain, three capture cycles
        d0 = done_cnt4;
        start4(4'h9, 4'h9, 4'hF);
        repeat (13) @(negedge clk);
        chk("t6_captured", if4.captured, 4'h9);
        chk("t6_pass", if4.pass, 1);
        chk("t6_latency", done_t4, 11);
        chk("t6_done_pulses", done_cnt4 - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scan_seq_ctrl.md
Name: scan_seq_ctrl

Overview:
- Sequences a single scan chain such as my_reg through one full scan test: shift-in (load), functional capture, shift-out (unload), then compare against an expected vector.
- Sits between a host/test controller and the chain's scan_in0/scan_en/test_mode/scan_out0 pins.
- Replaces hand-driven scan stimulus in benches and on-chip self-test.

Parameters:
- CHAIN_LEN, 8, number of flops in the scan chain (≥2).
- CAPTURE_CYCLES, 1, functional clock cycles with scan_en=0 between load and unload (≥1).
- CNT_W, derived localparam = clog2(max(CHAIN_LEN, CAPTURE_CYCLES)+1), counter width; not overridable.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- start  input  1  request one scan test; sampled only in IDLE.
- pattern  input  CHAIN_LEN  load vector; bit i shifted on load cycle i (LSB first).
- expect_vec  input  CHAIN_LEN  expected unload vector.
- mask  input  CHAIN_LEN  compare mask; 1 = bit checked.
- scan_out0  input  1  chain tail output from DUT.
- scan_in0  output  1  chain head input to DUT.
- scan_en  output  1  shift enable to DUT.
- test_mode  output  1  DUT test mode select.
- busy  output  1  high from LOAD through UNLOAD.
- done  output  1  one-cycle pulse when result valid.
- pass  output  1  compare result; held until next accepted start.
- captured  output  CHAIN_LEN  unloaded vector; held until next accepted start.

Behaviour:
- Reset (reset=0, async): state=IDLE; scan_in0, scan_en, test_mode, busy, done, pass = 0; captured=0; counters=0.
- States: IDLE, LOAD, CAPTURE, UNLOAD, DONE.
- IDLE: all chain outputs 0. When start=1 at an edge: latch pattern/expect_vec/mask into shadow regs, clear captured and pass, go to LOAD. Inputs may change after that edge.
- LOAD, CHAIN_LEN cycles:
  - scan_en=1, test_mode=1, busy=1.
  - scan_in0 = shadow pattern bit k on load cycle k (k=0..CHAIN_LEN-1), registered output.
  - After the last cycle, go to CAPTURE.
- CAPTURE, CAPTURE_CYCLES cycles: scan_en=0, test_mode=1, scan_in0=0, busy=1; then go to UNLOAD.
- UNLOAD, CHAIN_LEN cycles:
  - scan_en=1, test_mode=1, scan_in0=0, busy=1.
  - At the edge closing unload cycle j, captured[j] <= scan_out0 (value before that edge's shift).
  - After the last cycle, go to DONE.
- DONE, 1 cycle:
  - done=1; pass = (((captured ^ expect_shadow) & mask_shadow) == 0); scan_en=0, test_mode=0, busy=0.
  - Next state IDLE.
- Latency: start sampled at edge 0 gives done high in the cycle after edge 2*CHAIN_LEN+CAPTURE_CYCLES (17 for defaults).
- Ordering property: for a pure-shift chain (capture holds state), captured == pattern.
- start while not IDLE (including the DONE cycle) is ignored; no queuing.
- mask=0 gives pass=1 regardless of captured.
- Reset asserted mid-operation aborts immediately: no done pulse, all outputs 0; the next test requires a new start.
- scan_en and test_mode are glitch-free registered outputs; scan_en never toggles within one state.

Decomposition:
- Shared package scan_pkg: state enum (IDLE, LOAD, CAPTURE, UNLOAD, DONE) and default CHAIN_LEN constant.
- One sub-module, scan_shift_cnt: a loadable down-counter with zero flag, reused for the LOAD, CAPTURE and UNLOAD durations.
- Compare logic stays inline.

Test Plan:
- Pure-shift 8-bit chain model, pattern=0xA5, expect=0xA5, mask=0xFF -> scan_en high for edges 1–8 and 10–17, low during edge 9; done pulses 17 cycles after start; captured=0xA5; pass=1.
- Chain model whose capture inverts contents, pattern=0x3C, expect=0xC3, mask=0xFF -> captured=0xC3, pass=1; rerun with expect=0x3C -> pass=0.
- Same inverting chain, pattern=0x3C, expect=0x00, mask=0x00 -> pass=1; expect=0xC2, mask=0x01 -> pass=0.
- start pulsed again during LOAD and during DONE -> ignored: single done pulse; busy low for at least one IDLE cycle before the next accepted start.
- reset driven low mid-UNLOAD (cycle 12) -> all outputs 0 asynchronously, no done; after release, start with 0xFF -> normal pass=1 with captured=0xFF.
- CAPTURE_CYCLES=3, CHAIN_LEN=4, pattern=0x9 -> done at cycle 11; captured=0x9 on the pure-shift model.
